mem_arbiter: RTL

Two-requester controller for the 16-bit-interface memory block. It owns the memory's addr_en/in_en/out_en strobes and sequences each transaction through the memory's address-latch, access and registered-read timing. Requester 0 is the CPU; requester 1 is the loader/debug port. Arbitration is round-robin, and out-of-range addresses are rejected without touching memory.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 50 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACCESS,
    CAPTURE,
    ACK
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant logic. Round-robin by default; MEM_ARB_FIXED_PRIO_EN makes port 0 always win.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       done_port,
  output logic [1:0] grant,
  output logic       grant_idx
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{clk, rst, update, done_port};

  always_comb begin
    grant_idx = PORT_CPU;
    if (!req[PORT_CPU] && req[PORT_LDR]) grant_idx = PORT_LDR;
  end
`else
  // ptr names the port that wins the next simultaneous request
  logic ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PORT_CPU;
    end else if (update) begin
      ptr <= ~done_port;
    end
  end

  always_comb begin
    grant_idx = PORT_CPU;
    case (req)
      2'b01:   grant_idx = PORT_CPU;
      2'b10:   grant_idx = PORT_LDR;
      2'b11:   grant_idx = ptr;
      default: grant_idx = PORT_CPU;
    endcase
  end
`endif

  always_comb begin
    grant = 2'b00;
    if (req != 2'b00) grant = port_onehot(grant_idx);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester controller for the 16-bit memory block; sequences addr-latch, access and registered read.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (port 0 wins simultaneous requests).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_SIZE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [1:0]        grant,
  output logic              mem_addr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_in_en,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_out_en,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_SIZE);

  state_t            state, state_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        grant_q;
  logic              err_q;

  logic [1:0]        arb_grant;
  logic              arb_idx;
  logic              start;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1, req0}),
    .update    (state == ACK),
    .done_port (grant_q[1]),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign start     = (state == IDLE) && (req0 || req1);
  assign sel_we    = arb_idx ? we1    : we0;
  assign sel_addr  = arb_idx ? addr1  : addr0;
  assign sel_wdata = arb_idx ? wdata1 : wdata0;
  assign in_range  = {1'b0, sel_addr} < LIMIT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields are captured only in IDLE so later requester changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 2'b00;
      err_q   <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (start) begin
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        grant_q <= arb_grant;
        err_q   <= !in_range;
      end else if (state == ACK) begin
        grant_q <= 2'b00;
        err_q   <= 1'b0;
      end
      if (state == CAPTURE) begin
        if (grant_q[0]) rdata0 <= mem_out;
        if (grant_q[1]) rdata1 <= mem_out;
      end
    end
  end

  // Every output below decodes registered state only
  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    grant       = grant_q;
    mem_addr_en = 1'b0;
    mem_addr    = '0;
    mem_in_en   = 1'b0;
    mem_in      = '0;
    mem_out_en  = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = in_range ? ADDR : ACK;
      end
      ADDR: begin
        mem_addr_en = 1'b1;
        mem_addr    = addr_q;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          mem_in_en = 1'b1;
          mem_in    = wdata_q;
          state_nxt = ACK;
        end else begin
          mem_out_en = 1'b1;
          state_nxt  = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = ACK;
      end
      ACK: begin
        ack0      = grant_q[0];
        ack1      = grant_q[1];
        err0      = grant_q[0] && err_q;
        err1      = grant_q[1] && err_q;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
